// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: one-cycle registered branch evaluation with a handshake,
// misprediction detection, a 2-bit-counter BHT trained at retirement, and
// saturating retirement statistics.

package branches_pkg;

  // Encoding matches the conditional-branch funct3 field; 3'b010/3'b011 are unused.
  typedef enum logic [2:0] {
    BrEq  = 3'b000,
    BrNe  = 3'b001,
    BrLt  = 3'b100,
    BrGe  = 3'b101,
    BrLtu = 3'b110,
    BrGeu = 3'b111
  } branch_op_e;

endpackage

module branch_resolve_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       is_branch,
  input  branches_pkg::branch_op_e   branch_op,
  input  logic [WIDTH-1:0]           src_a,
  input  logic [WIDTH-1:0]           src_b,
  input  logic [WIDTH-1:0]           pc,
  input  logic [WIDTH-1:0]           imm,
  input  logic                       pred_taken,
  input  logic [WIDTH-1:0]           pred_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       taken,
  output logic [WIDTH-1:0]           next_pc,
  output logic                       mispredict,
  input  logic [WIDTH-1:0]           lookup_pc,
  output logic                       lookup_taken,
  output logic [CNT_WIDTH-1:0]       branch_count,
  output logic [CNT_WIDTH-1:0]       mispredict_count
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  // Result register and the retirement context carried alongside it
  logic             out_valid_q, out_valid_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic             mispredict_q, mispredict_d;
  logic             is_branch_q, is_branch_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  logic             accept;
  logic             retire_branch;
  logic             cond;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] seq_pc;
  logic             res_taken;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // A flush in the same cycle as out_ready drops the result instead of retiring it
  assign retire_branch = out_valid_q && out_ready && !flush && is_branch_q;

  // Branch condition from the comparison select; unused encodings never take
  always_comb begin
    cond = 1'b0;
    unique case (branch_op)
      branches_pkg::BrEq:  cond = (src_a == src_b);
      branches_pkg::BrNe:  cond = (src_a != src_b);
      branches_pkg::BrLt:  cond = ($signed(src_a) < $signed(src_b));
      branches_pkg::BrGe:  cond = ($signed(src_a) >= $signed(src_b));
      branches_pkg::BrLtu: cond = (src_a < src_b);
      branches_pkg::BrGeu: cond = (src_a >= src_b);
      default:             cond = 1'b0;
    endcase
  end

  assign target    = pc + imm;
  assign seq_pc    = pc + WIDTH'(4);
  assign res_taken = is_branch && cond;

  // Next-state for the result register: load on accept, drain on out_ready, kill on flush
  always_comb begin
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    next_pc_d    = next_pc_q;
    mispredict_d = mispredict_q;
    is_branch_d  = is_branch_q;
    idx_d        = idx_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      taken_d      = res_taken;
      next_pc_d    = res_taken ? target : seq_pc;
      mispredict_d = is_branch &&
                     ((pred_taken != res_taken) || (res_taken && (pred_target != target)));
      is_branch_d  = is_branch;
      idx_d        = pc[IdxW+1:2];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      next_pc_q    <= '0;
      mispredict_q <= 1'b0;
      is_branch_q  <= 1'b0;
      idx_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      next_pc_q    <= next_pc_d;
      mispredict_q <= mispredict_d;
      is_branch_q  <= is_branch_d;
      idx_q        <= idx_d;
    end
  end

  // BHT training: saturating 2-bit counter step on each retired branch
  always_comb begin
    for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
      bht_d[i] = bht_q[i];
    end
    if (retire_branch) begin
      if (taken_q) begin
        if (bht_q[idx_q] != 2'b11) bht_d[idx_q] = bht_q[idx_q] + 2'b01;
      end else begin
        if (bht_q[idx_q] != 2'b00) bht_d[idx_q] = bht_q[idx_q] - 2'b01;
      end
    end
  end

  // BHT storage; every entry resets to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  // Retirement statistics, saturating at all-ones
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (retire_branch) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + CNT_WIDTH'(1);
      if (mispredict_q && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
      end
    end
  end

  // Statistics counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible yet
  assign lookup_taken     = bht_q[lookup_pc[IdxW+1:2]][1];
  assign out_valid        = out_valid_q;
  assign taken            = taken_q;
  assign next_pc          = next_pc_q;
  assign mispredict       = mispredict_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.

module tb_branch_resolve_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] OpEq  = 3'b000;
  localparam logic [2:0] OpNe  = 3'b001;
  localparam logic [2:0] OpLt  = 3'b100;
  localparam logic [2:0] OpGe  = 3'b101;
  localparam logic [2:0] OpLtu = 3'b110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic is_branch = 1'b0;
  branches_pkg::branch_op_e branch_op = branches_pkg::BrEq;
  logic [WIDTH-1:0] src_a = '0, src_b = '0, pc = '0, imm = '0, pred_target = '0;
  logic pred_taken = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic taken;
  logic [WIDTH-1:0] next_pc;
  logic mispredict;
  logic [WIDTH-1:0] lookup_pc = '0;
  logic lookup_taken;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(
    .WIDTH(WIDTH), .BHT_ENTRIES(64), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .branch_op(branch_op), .src_a(src_a), .src_b(src_b), .pc(pc),
    .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .next_pc(next_pc), .mispredict(mispredict),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present inputs without waiting
  task automatic drive(input logic br, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                       input logic pt, input logic [31:0] ptg);
    in_valid    = 1'b1;
    is_branch   = br;
    branch_op   = branches_pkg::branch_op_e'(op);
    src_a       = a;
    src_b       = b;
    pc          = p;
    imm         = i;
    pred_taken  = pt;
    pred_target = ptg;
  endtask

  // Present one op for one edge (assumes in_ready)
  task automatic send(input logic br, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                      input logic pt, input logic [31:0] ptg);
    drive(br, op, a, b, p, i, pt, ptg);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic t,
                           input logic [31:0] npc, input logic m);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".taken"}, 64'(taken), 64'(t));
    check({tag, ".next_pc"}, 64'(next_pc), 64'(npc));
    check({tag, ".mispredict"}, 64'(mispredict), 64'(m));
  endtask

  task automatic check_cnt(input string tag, input int bc, input int mc);
    check({tag, ".branch_count"}, 64'(branch_count), 64'(bc));
    check({tag, ".mispredict_count"}, 64'(mispredict_count), 64'(mc));
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] p, input logic exp);
    lookup_pc = p;
    #0;
    check(tag, 64'(lookup_taken), 64'(exp));
  endtask

  initial begin
    // Reset state
    step();
    check_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    check_cnt("reset", 0, 0);
    check_lookup("reset.lookup", 32'h100, 1'b0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // BEQ taken, predicted not-taken
    send(1'b1, OpEq, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 32'h0);
    check_out("beq", 1'b1, 1'b1, 32'h120, 1'b1);
    check_lookup("beq.pre_update_lookup", 32'h100, 1'b0);
    step();
    check("beq.drained", 64'(out_valid), 64'd0);
    check_cnt("beq", 1, 1);
    check_lookup("beq.lookup", 32'h100, 1'b1);

    // Signed vs unsigned less-than
    send(1'b1, OpLt, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 32'h240);
    check_out("blt", 1'b1, 1'b1, 32'h240, 1'b0);
    step();
    send(1'b1, OpLtu, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 1'b0, 32'h0);
    check_out("bltu", 1'b1, 1'b0, 32'h304, 1'b0);
    step();
    check_cnt("blt_bltu", 3, 1);

    // Non-branch never mispredicts nor counts
    send(1'b0, OpEq, 32'h7, 32'h7, 32'h400, 32'h8, 1'b1, 32'h1234);
    check_out("nonbr", 1'b1, 1'b0, 32'h404, 1'b0);
    step();
    check_cnt("nonbr", 3, 1);

    // Back-pressure: second op waits, then accepted on the out_ready cycle
    out_ready = 1'b0;
    send(1'b1, OpNe, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1, 32'h510);
    drive(1'b1, OpGe, 32'h3, 32'h3, 32'h600, 32'h20, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      check("stall.in_ready", 64'(in_ready), 64'd0);
      check_out("stall", 1'b1, 1'b1, 32'h510, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #0;
    check("stall.in_ready_release", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_out("bge_after_stall", 1'b1, 1'b1, 32'h620, 1'b1);
    check_cnt("stall_first_retired", 4, 1);
    step();
    check_cnt("stall_both_retired", 5, 2);

    // PC wrap-around
    send(1'b1, OpNe, 32'h1, 32'h1, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0);
    check_out("wrap_nt", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    send(1'b1, OpNe, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4);
    check_out("wrap_t", 1'b1, 1'b1, 32'h4, 1'b0);
    step();
    check_cnt("wrap", 7, 2);

    // Counter saturation at 3: four taken, then one not-taken must still predict taken
    for (int k = 0; k < 4; k++) begin
      send(1'b1, OpEq, 32'h9, 32'h9, 32'h704, 32'h10, 1'b1, 32'h714);
      step();
    end
    check_lookup("sat_hi.lookup", 32'h704, 1'b1);
    send(1'b1, OpEq, 32'h1, 32'h2, 32'h704, 32'h10, 1'b0, 32'h0);
    step();
    check_lookup("sat_hi.after_one_nt", 32'h704, 1'b1);
    // Three more not-taken reach 0; two taken must then be needed to predict taken
    for (int k = 0; k < 3; k++) begin
      send(1'b1, OpEq, 32'h1, 32'h2, 32'h704, 32'h10, 1'b0, 32'h0);
      step();
    end
    check_lookup("sat_lo.lookup", 32'h704, 1'b0);
    send(1'b1, OpEq, 32'h9, 32'h9, 32'h704, 32'h10, 1'b1, 32'h714);
    step();
    check_lookup("sat_lo.after_one_t", 32'h704, 1'b0);
    send(1'b1, OpEq, 32'h9, 32'h9, 32'h704, 32'h10, 1'b1, 32'h714);
    step();
    check_lookup("sat_lo.after_two_t", 32'h704, 1'b1);
    check_cnt("sat", 17, 2);

    // Flush with out_ready drops a not-taken mispredicted result untrained
    send(1'b1, OpEq, 32'h1, 32'h2, 32'h704, 32'h10, 1'b1, 32'h714);
    check_out("pre_flush", 1'b1, 1'b0, 32'h708, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check_cnt("flush", 17, 2);
    check_lookup("flush.lookup", 32'h704, 1'b1);

    // Asynchronous reset mid-transaction
    send(1'b1, OpEq, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120);
    check("pre_reset.out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 32'h0, 1'b0);
    check_cnt("async_reset", 0, 0);
    check_lookup("async_reset.lookup_100", 32'h100, 1'b0);
    check_lookup("async_reset.lookup_704", 32'h704, 1'b0);
    check_lookup("async_reset.lookup_wrap", 32'hFFFF_FFFC, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
